// File: rtl/spi_slave_4byte_if.sv
// Pin and host-side bundle for spi_slave_4byte: SPI pads, mode straps, TX buffer and RX word ports.
interface spi_slave_4byte_if #(parameter int C = 32) ();
   logic         SPI_CLK;
   logic         SPI_SS;
   logic         MOSI;
   logic         MISO;
   logic         MISO_OE;
   logic         CPOL;
   logic         CPHA;
   logic [C-1:0] din;
   logic         tx_load;
   logic         tx_ready;
   logic [C-1:0] dout;
   logic         valid;
   logic         underrun;
   logic         frame_err;

   modport slave (
      input  SPI_CLK, SPI_SS, MOSI, CPOL, CPHA, din, tx_load,
      output MISO, MISO_OE, tx_ready, dout, valid, underrun, frame_err
   );

   modport master (
      output SPI_CLK, SPI_SS, MOSI, CPOL, CPHA, din, tx_load,
      input  MISO, MISO_OE, tx_ready, dout, valid, underrun, frame_err
   );
endinterface

// File: rtl/spi_slave_4byte.sv
// Oversampled SPI slave (all four modes): C-bit words, single TX buffer, back-to-back words per SS.
// Define SPI_SLAVE_FRAME_ERR_EN to flag frames that end with a partial word on frame_err.
module spi_slave_4byte #(
   parameter int C           = 32,
   parameter int SYNC_STAGES = 2
) (
   input logic              CLK_IN,
   input logic              RST_IN,
   spi_slave_4byte_if.slave bus
);
   localparam int CW = $clog2(C + 1);
   localparam int SW = $clog2(SYNC_STAGES + 2);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t         state_reg, state_next;
   logic [2:0]     pin_raw, pin_idle, pin_s;
   logic           sck_s, ss_s, mosi_s;
   logic           sck_d_reg, ss_d_reg;
   logic           cpol_reg, cpha_reg;
   logic [SW-1:0]  settle_reg;
   logic           armed_reg;
   logic [CW-1:0]  cnt_reg;
   logic [C-1:0]   rx_shift_reg, tx_shift_reg, tx_buf_reg, dout_reg;
   logic           tx_ready_reg, valid_reg, underrun_reg, frame_err_reg;
   logic           skip_reg, pend_reg;
   logic           p_now, p_prev, ss_fall, ss_rise;
   logic           start, frame_end, sample_ev, shift_ev, word_done, load_ev;

   assign pin_raw  = {bus.MOSI, bus.SPI_SS, bus.SPI_CLK};
   assign pin_idle = {1'b0, 1'b1, bus.CPOL};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         logic [SYNC_STAGES-1:0] chain_reg;
         always_ff @(posedge CLK_IN) begin
            if (RST_IN)
               chain_reg <= {SYNC_STAGES{pin_idle[gi]}};
            else
               chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_raw[gi]};
         end
         assign pin_s[gi] = chain_reg[SYNC_STAGES-1];
      end
   endgenerate

   assign sck_s  = pin_s[0];
   assign ss_s   = pin_s[1];
   assign mosi_s = pin_s[2];

   assign p_now   = sck_s ^ cpol_reg ^ cpha_reg;
   assign p_prev  = sck_d_reg ^ cpol_reg ^ cpha_reg;
   // A falling SS is only trusted once the synchronizer has shown SS high after reset.
   assign ss_fall = ss_d_reg & ~ss_s & armed_reg;
   assign ss_rise = ~ss_d_reg & ss_s;
   assign load_ev = start | word_done;

   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      frame_end  = 1'b0;
      sample_ev  = 1'b0;
      shift_ev   = 1'b0;
      word_done  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ss_fall) begin
               state_next = ACTIVE;
               start      = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_next = IDLE;
               frame_end  = 1'b1;
            end else begin
               sample_ev = p_now & ~p_prev;
               shift_ev  = ~p_now & p_prev;
               word_done = sample_ev && (cnt_reg == CW'(C - 1));
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK_IN) begin
      if (RST_IN)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         sck_d_reg     <= bus.CPOL;
         ss_d_reg      <= 1'b1;
         cpol_reg      <= bus.CPOL;
         cpha_reg      <= bus.CPHA;
         settle_reg    <= '0;
         armed_reg     <= 1'b0;
         cnt_reg       <= '0;
         rx_shift_reg  <= '0;
         tx_shift_reg  <= '0;
         tx_buf_reg    <= '0;
         dout_reg      <= '0;
         tx_ready_reg  <= 1'b1;
         valid_reg     <= 1'b0;
         underrun_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         skip_reg      <= 1'b0;
         pend_reg      <= 1'b0;
      end else begin
         sck_d_reg     <= sck_s;
         ss_d_reg      <= ss_s;
         valid_reg     <= 1'b0;
         underrun_reg  <= 1'b0;
         frame_err_reg <= 1'b0;

         if (state_reg == IDLE && ss_s) begin
            cpol_reg <= bus.CPOL;
            cpha_reg <= bus.CPHA;
         end

         if (settle_reg != SW'(SYNC_STAGES + 1))
            settle_reg <= settle_reg + SW'(1);
         else if (ss_s)
            armed_reg <= 1'b1;

         if (start) begin
            cnt_reg      <= '0;
            rx_shift_reg <= '0;
            skip_reg     <= cpha_reg;
            pend_reg     <= 1'b0;
         end

         if (word_done) begin
            dout_reg     <= {mosi_s, rx_shift_reg[C-1:1]};
            valid_reg    <= 1'b1;
            cnt_reg      <= '0;
            rx_shift_reg <= '0;
            // The edge that follows the last sample is a shift edge in every mode; it must not eat the new MSB.
            skip_reg     <= 1'b1;
         end else if (sample_ev) begin
            rx_shift_reg <= {mosi_s, rx_shift_reg[C-1:1]};
            cnt_reg      <= cnt_reg + CW'(1);
            if (pend_reg) begin
               underrun_reg <= 1'b1;
               pend_reg     <= 1'b0;
            end
         end

         if (shift_ev) begin
            if (skip_reg)
               skip_reg <= 1'b0;
            else
               tx_shift_reg <= tx_shift_reg << 1;
         end

         // A consumption and a host load in the same cycle: the load is dropped.
         if (load_ev) begin
            if (!tx_ready_reg) begin
               tx_shift_reg <= tx_buf_reg;
               tx_ready_reg <= 1'b1;
            end else begin
               tx_shift_reg <= '0;
               // Mid-frame underrun is reported only if the master actually clocks the next word.
               if (start)
                  underrun_reg <= 1'b1;
               else
                  pend_reg <= 1'b1;
            end
         end else if (bus.tx_load && tx_ready_reg) begin
            tx_buf_reg   <= bus.din;
            tx_ready_reg <= 1'b0;
         end

         if (frame_end) begin
            pend_reg <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_reg <= (cnt_reg != '0);
`else
            frame_err_reg <= 1'b0;
`endif
         end
      end
   end

   assign bus.MISO      = (state_reg == ACTIVE) ? tx_shift_reg[C-1] : 1'b0;
   assign bus.MISO_OE   = ~ss_s;
   assign bus.tx_ready  = tx_ready_reg;
   assign bus.dout      = dout_reg;
   assign bus.valid     = valid_reg;
   assign bus.underrun  = underrun_reg;
   assign bus.frame_err = frame_err_reg;
endmodule

// File: tb/tb_spi_slave_4byte.sv
// Directed bench for spi_slave_4byte: bit-banged SPI master in all four modes with hand-computed words.
module tb_spi_slave_4byte;
   localparam int HALF = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_slave_4byte_if #(.C(32)) bus_if ();

   spi_slave_4byte #(.C(32), .SYNC_STAGES(2)) dut (
      .CLK_IN (clk),
      .RST_IN (rst),
      .bus    (bus_if.slave)
   );

   int          n_vec = 0;
   int          n_bad = 0;
   int          valid_cnt = 0;
   int          und_cnt = 0;
   int          ferr_cnt = 0;
   logic [31:0] vals [32];
   logic [31:0] r0, r1;
   int          base, u0, f0;
   logic [31:0] ferr_exp;
   logic [1:0]  modes [4];

   always @(negedge clk) begin
      if (!rst) begin
         if (bus_if.valid) begin
            if (valid_cnt < 32) vals[valid_cnt] = bus_if.dout;
            valid_cnt++;
         end
         if (bus_if.underrun) und_cnt++;
         if (bus_if.frame_err) ferr_cnt++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_tx(input logic [31:0] w);
      bus_if.din     = w;
      bus_if.tx_load = 1'b1;
      cyc(1);
      bus_if.tx_load = 1'b0;
   endtask

   // Master: sends up to two words LSB first, collects MISO MSB first.
   task automatic xfer(input logic [1:0] mode, input int nbits, input logic [31:0] w0,
                       input logic [31:0] w1, input int load_at, input logic [31:0] w_mid,
                       input bit rst_at_end, output logic [31:0] q0, output logic [31:0] q1);
      logic        cpol, cpha;
      logic [63:0] tx, rxm;
      cpol = mode[1];
      cpha = mode[0];
      tx   = {w1, w0};
      rxm  = '0;
      bus_if.CPOL    = cpol;
      bus_if.CPHA    = cpha;
      bus_if.SPI_CLK = cpol;
      cyc(HALF);
      bus_if.SPI_SS = 1'b0;
      if (!cpha) bus_if.MOSI = tx[0];
      cyc(2 * HALF);
      for (int i = 0; i < nbits; i++) begin
         if (i == load_at) load_tx(w_mid);
         if (cpha) begin
            bus_if.SPI_CLK = ~cpol;
            bus_if.MOSI    = tx[i];
            cyc(HALF);
            rxm = {rxm[62:0], bus_if.MISO};
            bus_if.SPI_CLK = cpol;
            cyc(HALF);
         end else begin
            cyc(HALF);
            rxm = {rxm[62:0], bus_if.MISO};
            bus_if.SPI_CLK = ~cpol;
            cyc(HALF);
            bus_if.SPI_CLK = cpol;
            bus_if.MOSI    = tx[(i + 1) % 64];
         end
      end
      cyc(HALF);
      if (rst_at_end) begin
         rst = 1'b1;
         cyc(2);
         rst = 1'b0;
         cyc(2);
      end
      bus_if.SPI_SS = 1'b1;
      cyc(4 * HALF);
      q0 = (nbits > 32) ? rxm[63:32] : rxm[31:0];
      q1 = rxm[31:0];
   endtask

   initial begin
      bus_if.SPI_CLK = 1'b0;
      bus_if.SPI_SS  = 1'b1;
      bus_if.MOSI    = 1'b0;
      bus_if.CPOL    = 1'b0;
      bus_if.CPHA    = 1'b0;
      bus_if.din     = '0;
      bus_if.tx_load = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      ferr_exp = 32'd1;
`else
      ferr_exp = 32'd0;
`endif
      modes[0] = 2'd0;
      modes[1] = 2'd3;
      modes[2] = 2'd1;
      modes[3] = 2'd2;

      cyc(4);
      rst = 1'b0;
      cyc(1);
      chk("rst_tx_ready", {31'd0, bus_if.tx_ready}, 32'd1);
      chk("rst_valid", {31'd0, bus_if.valid}, 32'd0);
      chk("rst_miso", {31'd0, bus_if.MISO}, 32'd0);
      chk("rst_miso_oe", {31'd0, bus_if.MISO_OE}, 32'd0);
      chk("rst_dout", bus_if.dout, 32'd0);
      chk("rst_underrun", {31'd0, bus_if.underrun}, 32'd0);
      chk("rst_frame_err", {31'd0, bus_if.frame_err}, 32'd0);
      cyc(10);

      // Single word in each SPI mode, buffer preloaded.
      for (int m = 0; m < 4; m++) begin
         base = valid_cnt;
         u0   = und_cnt;
         f0   = ferr_cnt;
         load_tx(32'h1234_5678);
         chk($sformatf("m%0d_tx_ready_full", modes[m]), {31'd0, bus_if.tx_ready}, 32'd0);
         if (m == 0) load_tx(32'hFFFF_FFFF);
         xfer(modes[m], 32, 32'hA5A5_0F0F, 32'd0, -1, 32'd0, 1'b0, r0, r1);
         chk($sformatf("m%0d_valid_count", modes[m]), 32'(valid_cnt - base), 32'd1);
         chk($sformatf("m%0d_rx_word", modes[m]), vals[base], 32'hA5A5_0F0F);
         chk($sformatf("m%0d_dout", modes[m]), bus_if.dout, 32'hA5A5_0F0F);
         chk($sformatf("m%0d_master_rx", modes[m]), r0, 32'h1234_5678);
         chk($sformatf("m%0d_tx_ready_empty", modes[m]), {31'd0, bus_if.tx_ready}, 32'd1);
         chk($sformatf("m%0d_underrun", modes[m]), 32'(und_cnt - u0), 32'd0);
         chk($sformatf("m%0d_frame_err", modes[m]), 32'(ferr_cnt - f0), 32'd0);
      end

      // No tx_load before SS falls.
      base = valid_cnt;
      u0   = und_cnt;
      xfer(2'd0, 32, 32'h3C3C_3C3C, 32'd0, -1, 32'd0, 1'b0, r0, r1);
      chk("und_pulses", 32'(und_cnt - u0), 32'd1);
      chk("und_master_rx", r0, 32'd0);
      chk("und_valid_count", 32'(valid_cnt - base), 32'd1);
      chk("und_dout", bus_if.dout, 32'h3C3C_3C3C);

      // Two words under one SS, second buffer word loaded during the first.
      base = valid_cnt;
      u0   = und_cnt;
      load_tx(32'hCAFE_F00D);
      xfer(2'd0, 64, 32'h0000_0001, 32'hFFFF_FFFE, 10, 32'h0BAD_C0DE, 1'b0, r0, r1);
      chk("b2b_valid_count", 32'(valid_cnt - base), 32'd2);
      chk("b2b_word0", vals[base], 32'h0000_0001);
      chk("b2b_word1", vals[base + 1], 32'hFFFF_FFFE);
      chk("b2b_master_rx0", r0, 32'hCAFE_F00D);
      chk("b2b_master_rx1", r1, 32'h0BAD_C0DE);
      chk("b2b_underrun", 32'(und_cnt - u0), 32'd0);

      // Back-to-back in mode 3.
      base = valid_cnt;
      load_tx(32'h8000_0001);
      xfer(2'd3, 64, 32'h0F0F_F0F0, 32'h7E81_42BD, 5, 32'hC001_D00D, 1'b0, r0, r1);
      chk("b2b3_word0", vals[base], 32'h0F0F_F0F0);
      chk("b2b3_word1", vals[base + 1], 32'h7E81_42BD);
      chk("b2b3_master_rx0", r0, 32'h8000_0001);
      chk("b2b3_master_rx1", r1, 32'hC001_D00D);

      // SS raised after 17 bits.
      base = valid_cnt;
      f0   = ferr_cnt;
      xfer(2'd0, 17, 32'h0001_2345, 32'd0, -1, 32'd0, 1'b0, r0, r1);
      chk("part_valid_count", 32'(valid_cnt - base), 32'd0);
      chk("part_frame_err", 32'(ferr_cnt - f0), ferr_exp);
      chk("part_dout_held", bus_if.dout, 32'h7E81_42BD);

      // Reset at bit 10, then a full frame.
      base = valid_cnt;
      f0   = ferr_cnt;
      load_tx(32'h600D_F00D);
      xfer(2'd0, 10, 32'h5555_5555, 32'd0, -1, 32'd0, 1'b1, r0, r1);
      chk("rstmid_dout_cleared", bus_if.dout, 32'd0);
      chk("rstmid_tx_ready", {31'd0, bus_if.tx_ready}, 32'd1);
      load_tx(32'h1357_2468);
      xfer(2'd0, 32, 32'hDEAD_BEEF, 32'd0, -1, 32'd0, 1'b0, r0, r1);
      chk("rstmid_valid_count", 32'(valid_cnt - base), 32'd1);
      chk("rstmid_dout", bus_if.dout, 32'hDEAD_BEEF);
      chk("rstmid_frame_err", 32'(ferr_cnt - f0), 32'd0);
      chk("rstmid_master_rx", r0, 32'h1357_2468);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
